// File: rtl/traffic_pkg.sv
//------------------------------------------------------------------------------
// Module : traffic_pkg
// Brief  : Phase encodings, lamp-set constants and default timings for the
//          intersection phase scheduler.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_G    = 3'd0,
        MAIN_Y    = 3'd1,
        ALL_RED_A = 3'd2,
        SIDE_G    = 3'd3,
        SIDE_Y    = 3'd4,
        PED_WALK  = 3'd5,
        PED_CLR   = 3'd6,
        ALL_RED_B = 3'd7
    } phase_t;

    typedef enum logic {
        RR_SIDE = 1'b0,
        RR_PED  = 1'b1
    } requester_t;

    typedef struct packed {
        logic main_red;
        logic main_yellow;
        logic main_green;
        logic side_red;
        logic side_yellow;
        logic side_green;
        logic walk;
        logic walk_flash;
    } lamp_t;

    localparam lamp_t MAIN_GO   = '{main_green: 1'b1, side_red: 1'b1, default: 1'b0};
    localparam lamp_t MAIN_SLOW = '{main_yellow: 1'b1, side_red: 1'b1, default: 1'b0};
    localparam lamp_t SIDE_GO   = '{main_red: 1'b1, side_green: 1'b1, default: 1'b0};
    localparam lamp_t SIDE_SLOW = '{main_red: 1'b1, side_yellow: 1'b1, default: 1'b0};
    localparam lamp_t PED_GO    = '{main_red: 1'b1, side_red: 1'b1, walk: 1'b1, default: 1'b0};
    localparam lamp_t PED_CLEAR = '{main_red: 1'b1, side_red: 1'b1, walk_flash: 1'b1, default: 1'b0};
    localparam lamp_t ALL_STOP  = '{main_red: 1'b1, side_red: 1'b1, default: 1'b0};

    localparam int DEF_MAIN_MIN_GREEN  = 20;
    localparam int DEF_YELLOW_TIME     = 4;
    localparam int DEF_ALL_RED_TIME    = 2;
    localparam int DEF_SIDE_GREEN_TIME = 10;
    localparam int DEF_WALK_TIME       = 8;
    localparam int DEF_PED_CLEAR_TIME  = 6;
    localparam int DEF_TIMER_W         = 8;

    function automatic lamp_t lamps_for(input phase_t p);
        lamp_t l;
        case (p)
            MAIN_G:   l = MAIN_GO;
            MAIN_Y:   l = MAIN_SLOW;
            SIDE_G:   l = SIDE_GO;
            SIDE_Y:   l = SIDE_SLOW;
            PED_WALK: l = PED_GO;
            PED_CLR:  l = PED_CLEAR;
            default:  l = ALL_STOP;
        endcase
        return l;
    endfunction

endpackage

`default_nettype wire

// File: rtl/req_latch.sv
//------------------------------------------------------------------------------
// Module : req_latch
// Brief  : Synchronises one raw field input, detects its rising edge and holds
//          a pending request until the scheduler serves it.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module req_latch (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_raw,
    input  logic i_clr,
    output logic o_pend
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pend;
    logic w_rise;

    assign w_rise = r_sync2 & ~r_prev;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // A fresh rise wins over the serve-clear so a press during the
            // served phase is never lost.
            r_pend  <= w_rise | (r_pend & ~i_clr);
        end
    end

    assign o_pend = r_pend;

endmodule

`default_nettype wire

// File: rtl/intersection_phase_scheduler.sv
//------------------------------------------------------------------------------
// Module : intersection_phase_scheduler
// Brief  : Main-road-default light sequencer arbitrating side-road vehicle and
//          pedestrian requests round-robin, with registered lamp outputs.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MAIN_MIN_GREEN  = DEF_MAIN_MIN_GREEN,
    parameter int YELLOW_TIME     = DEF_YELLOW_TIME,
    parameter int ALL_RED_TIME    = DEF_ALL_RED_TIME,
    parameter int SIDE_GREEN_TIME = DEF_SIDE_GREEN_TIME,
    parameter int WALK_TIME       = DEF_WALK_TIME,
    parameter int PED_CLEAR_TIME  = DEF_PED_CLEAR_TIME,
    parameter int TIMER_W         = DEF_TIMER_W
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_Vs,
    input  logic       i_ped_btn,
    output logic       o_Main_red,
    output logic       o_Main_yellow,
    output logic       o_Main_green,
    output logic       o_Side_red,
    output logic       o_Side_yellow,
    output logic       o_Side_green,
    output logic       o_walk,
    output logic       o_walk_flash,
    output logic [2:0] o_phase,
    output logic       o_ped_wait
);

    phase_t               r_state;
    phase_t               w_next;
    requester_t           r_rr_last;
    requester_t           w_rr_next;
    logic [TIMER_W-1:0]   r_timer;
    lamp_t                r_lamps;
    logic                 w_expired;
    logic                 w_side_pend;
    logic                 w_ped_pend;
    logic                 w_side_clr;
    logic                 w_ped_clr;

    function automatic logic [TIMER_W-1:0] load_value(input phase_t p);
        logic [TIMER_W-1:0] v;
        case (p)
            MAIN_G:              v = TIMER_W'(MAIN_MIN_GREEN - 1);
            MAIN_Y, SIDE_Y:      v = TIMER_W'(YELLOW_TIME - 1);
            SIDE_G:              v = TIMER_W'(SIDE_GREEN_TIME - 1);
            PED_WALK:            v = TIMER_W'(WALK_TIME - 1);
            PED_CLR:             v = TIMER_W'(PED_CLEAR_TIME - 1);
            default:             v = TIMER_W'(ALL_RED_TIME - 1);
        endcase
        return v;
    endfunction

    req_latch u_side_req (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_raw     (i_Vs),
        .i_clr     (w_side_clr),
        .o_pend    (w_side_pend)
    );

    req_latch u_ped_req (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_raw     (i_ped_btn),
        .i_clr     (w_ped_clr),
        .o_pend    (w_ped_pend)
    );

    assign w_expired  = (r_timer == '0);
    assign w_side_clr = (w_next == SIDE_G)   && (r_state != SIDE_G);
    assign w_ped_clr  = (w_next == PED_WALK) && (r_state != PED_WALK);

    always_comb begin
        w_next    = r_state;
        w_rr_next = r_rr_last;
        case (r_state)
            MAIN_G: begin
                if (w_expired && (w_side_pend || w_ped_pend)) w_next = MAIN_Y;
            end
            MAIN_Y: begin
                if (w_expired) w_next = ALL_RED_A;
            end
            ALL_RED_A: begin
                if (w_expired) begin
                    // Round-robin only matters on a tie; a lone requester is
                    // served without disturbing the tie-break history.
                    if (w_side_pend && w_ped_pend) begin
                        if (r_rr_last == RR_PED) begin
                            w_next    = SIDE_G;
                            w_rr_next = RR_SIDE;
                        end else begin
                            w_next    = PED_WALK;
                            w_rr_next = RR_PED;
                        end
                    end else if (w_side_pend) begin
                        w_next = SIDE_G;
                    end else if (w_ped_pend) begin
                        w_next = PED_WALK;
                    end else begin
                        w_next = MAIN_G;
                    end
                end
            end
            SIDE_G: begin
                if (w_expired) w_next = SIDE_Y;
            end
            SIDE_Y: begin
                if (w_expired) w_next = ALL_RED_B;
            end
            PED_WALK: begin
                if (w_expired) w_next = PED_CLR;
            end
            PED_CLR: begin
                if (w_expired) w_next = ALL_RED_B;
            end
            ALL_RED_B: begin
                if (w_expired) w_next = MAIN_G;
            end
            default: begin
                w_next = MAIN_G;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= MAIN_G;
            r_rr_last <= RR_PED;
            r_timer   <= TIMER_W'(MAIN_MIN_GREEN - 1);
            r_lamps   <= MAIN_GO;
        end else begin
            r_state   <= w_next;
            r_rr_last <= w_rr_next;
            r_lamps   <= lamps_for(w_next);
            // Saturating countdown: MAIN_G parks at zero while idle.
            if (w_next != r_state) begin
                r_timer <= load_value(w_next);
            end else if (!w_expired) begin
                r_timer <= r_timer - 1'b1;
            end
        end
    end

    assign o_phase       = r_state;
    assign o_Main_red    = r_lamps.main_red;
    assign o_Main_yellow = r_lamps.main_yellow;
    assign o_Main_green  = r_lamps.main_green;
    assign o_Side_red    = r_lamps.side_red;
    assign o_Side_yellow = r_lamps.side_yellow;
    assign o_Side_green  = r_lamps.side_green;
    assign o_walk        = r_lamps.walk;
    assign o_walk_flash  = r_lamps.walk_flash;
    assign o_ped_wait    = w_ped_pend;

endmodule

`default_nettype wire

// File: tb/tb_intersection_phase_scheduler.sv
//------------------------------------------------------------------------------
// Module : tb_intersection_phase_scheduler
// Brief  : Self-checking bench for intersection_phase_scheduler.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_intersection_phase_scheduler;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       vs    = 1'b0;
    logic       ped   = 1'b0;
    logic       main_r, main_y, main_g, side_r, side_y, side_g;
    logic       walk, walk_flash, ped_wait;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;
    int e      = 0;

    // Reference model: phase number, cycles spent in phase, pending flags,
    // tie-break memory and a short delay line of sampled raw inputs.
    int m_phase;
    int m_cnt;
    bit m_sp, m_pp, m_rr_side;
    bit vh [3];
    bit ph [3];
    int dur [8] = '{20, 4, 2, 10, 4, 8, 6, 2};

    localparam logic [11:0] RESET_VEC = {3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    wire [11:0] dut_vec = {phase, main_r, main_y, main_g, side_r, side_y, side_g, walk, walk_flash, ped_wait};

    intersection_phase_scheduler dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_Vs          (vs),
        .i_ped_btn     (ped),
        .o_Main_red    (main_r),
        .o_Main_yellow (main_y),
        .o_Main_green  (main_g),
        .o_Side_red    (side_r),
        .o_Side_yellow (side_y),
        .o_Side_green  (side_g),
        .o_walk        (walk),
        .o_walk_flash  (walk_flash),
        .o_phase       (phase),
        .o_ped_wait    (ped_wait)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic logic [11:0] exp_vec(input int p, input bit pw);
        return {3'(p), (p != 0 && p != 1), (p == 1), (p == 0),
                (p != 3 && p != 4), (p == 4), (p == 3), (p == 5), (p == 6), pw};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_cnt = 1; m_sp = 0; m_pp = 0; m_rr_side = 0; e = 0;
            for (int i = 0; i < 3; i++) begin vh[i] = 0; ph[i] = 0; end
        end else begin
            bit rv, rp;
            int nx;
            rv = vh[1] & ~vh[2];
            rp = ph[1] & ~ph[2];
            vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = vs;
            ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = ped;
            nx = m_phase;
            if (m_phase == 0) begin
                if (m_cnt >= dur[0] && (m_sp || m_pp)) nx = 1;
            end else if (m_cnt >= dur[m_phase]) begin
                case (m_phase)
                    1: nx = 2;
                    2: begin
                        if (m_sp && m_pp) begin
                            nx = m_rr_side ? 5 : 3;
                            m_rr_side = (nx == 3);
                        end else if (m_sp) nx = 3;
                        else if (m_pp) nx = 5;
                        else nx = 0;
                    end
                    3: nx = 4;
                    4: nx = 7;
                    5: nx = 6;
                    6: nx = 7;
                    default: nx = 0;
                endcase
            end
            m_sp = rv | (m_sp & !(nx == 3 && m_phase != 3));
            m_pp = rp | (m_pp & !(nx == 5 && m_phase != 5));
            m_cnt = (nx != m_phase) ? 1 : m_cnt + 1;
            m_phase = nx;
            e = e + 1;
        end
    end

    // Leaves the bench just after a falling edge with no posedge seen yet.
    task automatic do_reset();
        rst_n = 1'b0;
        vs = 1'b0;
        ped = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", dut_vec, RESET_VEC);
        end
        do_reset();
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", dut_vec, RESET_VEC);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== RESET_VEC) begin
                errors++;
                $display("FAIL idle_cycle%0d: got %b expected %b", e, dut_vec, RESET_VEC);
            end
        end
    endtask

    task automatic test_side_sequence();
        int xp;
        do_reset();
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (e < 20) xp = 0;
            else if (e < 24) xp = 1;
            else if (e < 26) xp = 2;
            else if (e < 36) xp = 3;
            else if (e < 40) xp = 4;
            else if (e < 42) xp = 7;
            else xp = 0;
            checks++;
            if (dut_vec !== exp_vec(xp, 1'b0)) begin
                errors++;
                $display("FAIL side_seq_cycle%0d: got %b expected %b", e, dut_vec, exp_vec(xp, 1'b0));
            end
            if (e == 4) vs = 1'b1;
            if (e == 5) vs = 1'b0;
        end
    endtask

    task automatic test_ped();
        int walk_cnt = 0;
        int flash_cnt = 0;
        bit first_walk = 1'b1;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (e == 31) begin
                checks++;
                if (phase !== 3'd0) begin
                    errors++;
                    $display("FAIL ped_main_hold: got %0d expected 0", phase);
                end
            end
            if (e == 33) begin
                checks++;
                if (ped_wait !== 1'b1) begin
                    errors++;
                    $display("FAIL ped_wait_set: got %b expected 1", ped_wait);
                end
            end
            if (e == 34) begin
                checks++;
                if (phase !== 3'd1) begin
                    errors++;
                    $display("FAIL ped_main_yellow: got %0d expected 1", phase);
                end
            end
            if (walk || walk_flash) begin
                checks++;
                if ({main_r, main_y, main_g, side_r} !== 4'b1001) begin
                    errors++;
                    $display("FAIL ped_main_red: got %b expected 1001", {main_r, main_y, main_g, side_r});
                end
            end
            if (walk && first_walk) begin
                first_walk = 1'b0;
                checks++;
                if (ped_wait !== 1'b0) begin
                    errors++;
                    $display("FAIL ped_wait_clear: got %b expected 0", ped_wait);
                end
            end
            walk_cnt  += int'(walk);
            flash_cnt += int'(walk_flash);
            if (e == 29) ped = 1'b1;
            if (e == 35) ped = 1'b0;
        end
        checks++;
        if (walk_cnt != 8) begin
            errors++;
            $display("FAIL ped_walk_len: got %0d expected 8", walk_cnt);
        end
        checks++;
        if (flash_cnt != 6) begin
            errors++;
            $display("FAIL ped_flash_len: got %0d expected 6", flash_cnt);
        end
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL ped_return_main: got %b expected %b", dut_vec, RESET_VEC);
        end
    endtask

    // Records served phases (3/5) in order and lengths of main-green runs.
    task automatic observe(input int ncyc, output int served[$], output int runs[$]);
        int prev = 0;
        int run = 0;
        served = {};
        runs = {};
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (phase == 3'd0) run++;
            else if (prev == 0) begin runs.push_back(run); run = 0; end
            if ((phase == 3'd3 || phase == 3'd5) && int'(phase) != prev) served.push_back(int'(phase));
            prev = int'(phase);
            if (e == 1) begin vs = 1'b1; ped = 1'b1; end
            if (e == 3) begin vs = 1'b0; ped = 1'b0; end
        end
    endtask

    task automatic test_tie_rr();
        int served[$];
        int runs[$];
        do_reset();
        observe(120, served, runs);
        checks++;
        if (served.size() != 2 || served[0] != 3 || served[1] != 5) begin
            errors++;
            $display("FAIL tie_order: got %p expected '{3, 5}", served);
        end
        checks++;
        if (runs.size() < 2 || runs[1] != 20) begin
            errors++;
            $display("FAIL tie_main_gap: got %p expected second run 20", runs);
        end
        vs = 1'b1; ped = 1'b1;
        repeat (2) @(negedge clk);
        vs = 1'b0; ped = 1'b0;
        observe(40, served, runs);
        checks++;
        if (served.size() < 1 || served[0] != 5) begin
            errors++;
            $display("FAIL tie_second_order: got %p expected first 5", served);
        end
    endtask

    task automatic test_rearm();
        int prev = 0;
        int run = 0;
        int served[$];
        int runs[$];
        do_reset();
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (phase == 3'd0) run++;
            else if (prev == 0) begin runs.push_back(run); run = 0; end
            if (phase == 3'd3 && prev != 3) served.push_back(3);
            prev = int'(phase);
            if (e == 1 || e == 28) vs = 1'b1;
            if (e == 3 || e == 30) vs = 1'b0;
        end
        checks++;
        if (served.size() != 2) begin
            errors++;
            $display("FAIL rearm_count: got %0d expected 2", served.size());
        end
        checks++;
        if (runs.size() < 2 || runs[1] != 20) begin
            errors++;
            $display("FAIL rearm_main_gap: got %p expected second run 20", runs);
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        do_reset();
        ped = 1'b1;
        while (phase != 3'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (phase !== 3'd5) begin
            errors++;
            $display("FAIL areset_reach_walk: got %0d expected 5", phase);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL areset_immediate: got %b expected %b", dut_vec, RESET_VEC);
        end
        ped = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== RESET_VEC) begin
                errors++;
                $display("FAIL areset_resume_cycle%0d: got %b expected %b", e, dut_vec, RESET_VEC);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec(m_phase, m_pp)) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b expected %b", e, dut_vec, exp_vec(m_phase, m_pp));
            end
            if ($urandom_range(0, 29) == 0) vs = ~vs;
            if ($urandom_range(0, 39) == 0) ped = ~ped;
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_side_sequence();
        test_ped();
        test_tie_rr();
        test_rearm();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
